// File: rtl/md_ctrl_pkg.sv
// Shared types and default record widths for the MD core host-side controller.
package md_ctrl_pkg;

    localparam int D_IN_W  = 210;
    localparam int D_OUT_W = 192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_ACCEPT,
        ST_LD_HOLD,
        ST_COMPUTE,
        ST_RD_PULSE,
        ST_RD_GAP,
        ST_RD_PUSH,
        ST_FINISH
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/md_seq_timer.sv
// Loadable down-counter shared by the hold, compute, read-pulse and timeout intervals.
// Load has priority; otherwise counts down to zero and stays there.
module md_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (value_q != '0) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/md_run_sequencer.sv
// Host-side run controller for the MD core: loads particles with timed write windows,
// then per timestep waits the compute interval and unloads every particle to the host.
module md_run_sequencer
    import md_ctrl_pkg::*;
#(
    parameter int N_PARTICLES    = 300,
    parameter int D_IN_W         = md_ctrl_pkg::D_IN_W,
    parameter int D_OUT_W        = md_ctrl_pkg::D_OUT_W,
    parameter int WRITE_HOLD     = 16,
    parameter int READ_PULSE     = 16,
    parameter int COMPUTE_CYCLES = 10000,
    parameter int READ_TIMEOUT   = 64
) (
    input  logic               ap_clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        num_steps,
    output logic               busy,
    output logic               done,
    output logic               error,
    input  logic [D_IN_W-1:0]  host_in_data,
    input  logic               host_in_valid,
    output logic               host_in_ready,
    output logic [D_OUT_W-1:0] host_out_data,
    output logic               host_out_valid,
    input  logic               host_out_ready,
    output logic [D_IN_W-1:0]  md_d_in,
    output logic               md_elem_write,
    output logic [31:0]        md_step,
    output logic               md_read_ctrl,
    input  logic               md_elem_read,
    input  logic [D_OUT_W-1:0] md_d_out
);

    localparam int TMR_MAX = max3(COMPUTE_CYCLES, 2 * READ_PULSE, READ_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = $clog2(N_PARTICLES + 1);
    localparam int RD_SPAN = (2 * READ_PULSE > READ_TIMEOUT) ? 2 * READ_PULSE : READ_TIMEOUT;

    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(WRITE_HOLD - 1);
    localparam logic [TMR_W-1:0] COMP_LD   = TMR_W'(COMPUTE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RD_LD     = TMR_W'(RD_SPAN - 1);
    localparam logic [TMR_W-1:0] PULSE_END = TMR_W'(READ_PULSE - 1);
    localparam logic [TMR_W-1:0] GAP_END   = TMR_W'(2 * READ_PULSE - 1);
    localparam logic [TMR_W-1:0] TMO_END   = TMR_W'(READ_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_PARTICLES - 1);

    seq_state_e         state_q;
    logic [31:0]        steps_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        md_step_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               captured_q;
    logic [D_IN_W-1:0]  md_d_in_q;
    logic               md_elem_write_q;
    logic               md_read_ctrl_q;
    logic [D_OUT_W-1:0] host_out_data_q;
    logic               host_out_valid_q;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    logic               idx_last;
    logic [31:0]        step_inc;
    logic               run_over;
    logic [TMR_W-1:0]   rd_elapsed;
    logic               in_read;
    logic               cap_now;
    logic               have_result;
    logic               rd_timeout;

    assign idx_last    = (idx_q == IDX_LAST);
    assign step_inc    = md_step_q + 32'd1;
    assign run_over    = (step_inc == steps_q);
    // One timer covers both the pulse/gap schedule and the timeout, measured from pulse start.
    assign rd_elapsed  = RD_LD - tmr_val;
    assign in_read     = (state_q == ST_RD_PULSE) || (state_q == ST_RD_GAP);
    assign cap_now     = in_read && !captured_q && md_elem_read;
    assign have_result = captured_q || md_elem_read;
    assign rd_timeout  = !have_result && (rd_elapsed >= TMO_END);

    md_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (ap_clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_LD_ACCEPT: begin
                if (host_in_valid) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                end
            end
            ST_LD_HOLD: begin
                if (tmr_zero && idx_last && steps_q != 32'd0) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = COMP_LD;
                end
            end
            ST_COMPUTE: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = RD_LD;
                end
            end
            ST_RD_PUSH: begin
                if (host_out_ready) begin
                    if (!idx_last) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = RD_LD;
                    end else if (!run_over) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = COMP_LD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            steps_q          <= '0;
            idx_q            <= '0;
            md_step_q        <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            captured_q       <= 1'b0;
            md_d_in_q        <= '0;
            md_elem_write_q  <= 1'b0;
            md_read_ctrl_q   <= 1'b0;
            host_out_data_q  <= '0;
            host_out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cap_now) begin
                host_out_data_q <= md_d_out;
                captured_q      <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        steps_q   <= num_steps;
                        error_q   <= 1'b0;
                        md_step_q <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LD_ACCEPT;
                    end
                end
                ST_LD_ACCEPT: begin
                    if (host_in_valid) begin
                        md_d_in_q       <= host_in_data;
                        md_elem_write_q <= 1'b1;
                        state_q         <= ST_LD_HOLD;
                    end
                end
                ST_LD_HOLD: begin
                    if (tmr_zero) begin
                        md_elem_write_q <= 1'b0;
                        if (idx_last) begin
                            idx_q <= '0;
                            if (steps_q == 32'd0) begin
                                done_q  <= 1'b1;
                                state_q <= ST_FINISH;
                            end else begin
                                state_q <= ST_COMPUTE;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_LD_ACCEPT;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (tmr_zero) begin
                        md_read_ctrl_q <= 1'b1;
                        captured_q     <= 1'b0;
                        state_q        <= ST_RD_PULSE;
                    end
                end
                ST_RD_PULSE, ST_RD_GAP: begin
                    if (rd_timeout) begin
                        md_read_ctrl_q <= 1'b0;
                        error_q        <= 1'b1;
                        done_q         <= 1'b1;
                        state_q        <= ST_FINISH;
                    end else if (state_q == ST_RD_PULSE) begin
                        if (rd_elapsed == PULSE_END) begin
                            md_read_ctrl_q <= 1'b0;
                            state_q        <= ST_RD_GAP;
                        end
                    end else if (rd_elapsed >= GAP_END && have_result) begin
                        host_out_valid_q <= 1'b1;
                        state_q          <= ST_RD_PUSH;
                    end
                end
                ST_RD_PUSH: begin
                    if (host_out_ready) begin
                        host_out_valid_q <= 1'b0;
                        if (idx_last) begin
                            idx_q     <= '0;
                            md_step_q <= step_inc;
                            if (run_over) begin
                                done_q  <= 1'b1;
                                state_q <= ST_FINISH;
                            end else begin
                                state_q <= ST_COMPUTE;
                            end
                        end else begin
                            idx_q          <= idx_q + 1'b1;
                            md_read_ctrl_q <= 1'b1;
                            captured_q     <= 1'b0;
                            state_q        <= ST_RD_PULSE;
                        end
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign host_in_ready  = (state_q == ST_LD_ACCEPT);
    assign host_out_data  = host_out_data_q;
    assign host_out_valid = host_out_valid_q;
    assign md_d_in        = md_d_in_q;
    assign md_elem_write  = md_elem_write_q;
    assign md_step        = md_step_q;
    assign md_read_ctrl   = md_read_ctrl_q;

endmodule

// File: tb/tb_md_run_sequencer.sv
// Directed bench for md_run_sequencer with a small core model and host-side monitors.
module tb_md_run_sequencer;

    localparam int NP   = 4;
    localparam int DIW  = 210;
    localparam int DOW  = 192;
    localparam int WH   = 3;
    localparam int RP   = 4;
    localparam int CC   = 20;
    localparam int RTO  = 12;

    logic            ap_clk = 1'b0;
    logic            reset;
    logic            start;
    logic [31:0]     num_steps;
    logic            busy, done, error;
    logic [DIW-1:0]  host_in_data = DIW'(1);
    logic            host_in_valid;
    logic            host_in_ready;
    logic [DOW-1:0]  host_out_data;
    logic            host_out_valid;
    logic            host_out_ready;
    logic [DIW-1:0]  md_d_in;
    logic            md_elem_write;
    logic [31:0]     md_step;
    logic            md_read_ctrl;
    logic            md_elem_read = 1'b0;
    logic [DOW-1:0]  md_d_out = '0;

    int tests = 0;
    int fails = 0;
    logic core_en;

    md_run_sequencer #(
        .N_PARTICLES(NP), .D_IN_W(DIW), .D_OUT_W(DOW), .WRITE_HOLD(WH),
        .READ_PULSE(RP), .COMPUTE_CYCLES(CC), .READ_TIMEOUT(RTO)
    ) dut (
        .ap_clk(ap_clk), .reset(reset), .start(start), .num_steps(num_steps),
        .busy(busy), .done(done), .error(error),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .md_d_in(md_d_in), .md_elem_write(md_elem_write), .md_step(md_step),
        .md_read_ctrl(md_read_ctrl), .md_elem_read(md_elem_read), .md_d_out(md_d_out)
    );

    initial forever #5 ap_clk = ~ap_clk;

    // Monitor records
    int             wr_len[$];
    logic [DIW-1:0] wr_dat[$];
    int             wr_gap[$];
    int             wr_unstable = 0;
    int             rd_gap_q[$];
    int             rc_len_q[$];
    int             rc_rises = 0;
    logic [DOW-1:0] out_dat[$];
    logic [31:0]    out_step[$];
    int             done_cnt = 0;

    // Core model: one result 2 cycles after each md_read_ctrl rise, data 0xA0 + particle index.
    initial begin
        logic rc_prev;
        int   dly;
        int   rd_cnt;
        rc_prev = 1'b0;
        dly = 0;
        rd_cnt = 0;
        forever begin
            @(posedge ap_clk);
            #1;
            md_elem_read = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    md_elem_read = 1'b1;
                    md_d_out = DOW'(8'hA0 + rd_cnt % NP);
                    rd_cnt++;
                end
            end
            if (md_read_ctrl && !rc_prev && core_en) dly = 2;
            rc_prev = md_read_ctrl;
        end
    end

    // Host input feeder and output/strobe monitors, sampled late in the cycle.
    initial begin
        logic           hs_prev, rc_prev;
        int             in_cnt, cur_len, gap_cnt, since_wr, rc_len;
        logic [DIW-1:0] cur_dat;
        hs_prev = 0; rc_prev = 0; in_cnt = 0; cur_len = 0; gap_cnt = 0;
        since_wr = 0; rc_len = 0; cur_dat = '0;
        forever begin
            @(posedge ap_clk);
            #2;
            if (hs_prev) begin
                in_cnt++;
                host_in_data = DIW'(in_cnt + 1);
            end
            hs_prev = host_in_valid && host_in_ready;
            if (md_elem_write) begin
                if (cur_len == 0) begin
                    cur_dat = md_d_in;
                    if (wr_len.size() > 0) wr_gap.push_back(gap_cnt);
                end else if (md_d_in !== cur_dat) begin
                    wr_unstable++;
                end
                cur_len++;
            end else begin
                if (cur_len > 0) begin
                    wr_len.push_back(cur_len);
                    wr_dat.push_back(cur_dat);
                    gap_cnt = 1;
                end else begin
                    gap_cnt++;
                end
                cur_len = 0;
            end
            if (md_read_ctrl && !rc_prev) begin
                rc_rises++;
                rd_gap_q.push_back(since_wr);
                rc_len = 0;
            end
            if (md_read_ctrl) rc_len++;
            else if (rc_prev) rc_len_q.push_back(rc_len);
            rc_prev = md_read_ctrl;
            if (md_elem_write) since_wr = 0;
            else since_wr++;
            if (host_out_valid && host_out_ready) begin
                out_dat.push_back(host_out_data);
                out_step.push_back(md_step);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] steps);
        start = 1'b1;
        num_steps = steps;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL rst_error got %b exp 0", error); end
        tests++; if (host_in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", host_in_ready); end
        tests++; if (host_out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", host_out_valid); end
        tests++; if (md_elem_write !== 1'b0 || md_read_ctrl !== 1'b0) begin fails++; $display("FAIL rst_strobes got %b%b exp 00", md_elem_write, md_read_ctrl); end
        tests++; if (md_step !== 32'd0) begin fails++; $display("FAIL rst_step got %0d exp 0", md_step); end
        tests++; if (md_d_in !== '0 || host_out_data !== '0) begin fails++; $display("FAIL rst_data got %0h/%0h exp 0/0", md_d_in, host_out_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_unload();
        int wb, gb, rb, lb, ob, db;
        bit ok;
        wb = wr_len.size(); gb = wr_gap.size(); rb = rd_gap_q.size();
        lb = rc_len_q.size(); ob = out_dat.size(); db = done_cnt;
        pulse_start(32'd1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lu_busy got %b exp 1", busy); end
        wait_done(2000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL lu_done_timeout got 0 exp 1"); end
        tests++; if (md_step !== 32'd1) begin fails++; $display("FAIL lu_step got %0d exp 1", md_step); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lu_busy_at_done got %b exp 1", busy); end
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL lu_after_done busy/done got %b/%b exp 0/0", busy, done); end
        tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL lu_done_pulses got %0d exp 1", done_cnt - db); end
        tests++; if (wr_len.size() - wb !== NP) begin fails++; $display("FAIL lu_windows got %0d exp %0d", wr_len.size() - wb, NP); end
        for (int k = 0; k < NP; k++) begin
            tests++; if (wr_len[wb+k] !== WH) begin fails++; $display("FAIL lu_wlen[%0d] got %0d exp %0d", k, wr_len[wb+k], WH); end
            tests++; if (wr_dat[wb+k] !== DIW'(k + 1)) begin fails++; $display("FAIL lu_wdat[%0d] got %0h exp %0h", k, wr_dat[wb+k], k + 1); end
            tests++; if (out_dat[ob+k] !== DOW'(8'hA0 + k)) begin fails++; $display("FAIL lu_out[%0d] got %0h exp %0h", k, out_dat[ob+k], 8'hA0 + k); end
        end
        for (int k = 0; k < NP - 1; k++) begin
            tests++; if (wr_gap[gb+k] !== 1) begin fails++; $display("FAIL lu_wgap[%0d] got %0d exp 1", k, wr_gap[gb+k]); end
        end
        tests++; if (wr_unstable !== 0) begin fails++; $display("FAIL lu_din_stable got %0d exp 0", wr_unstable); end
        tests++; if (rd_gap_q[rb] !== CC) begin fails++; $display("FAIL lu_compute got %0d exp %0d", rd_gap_q[rb], CC); end
        tests++; if (rc_len_q[lb] !== RP) begin fails++; $display("FAIL lu_rd_pulse got %0d exp %0d", rc_len_q[lb], RP); end
        tests++; if (out_dat.size() - ob !== NP) begin fails++; $display("FAIL lu_nout got %0d exp %0d", out_dat.size() - ob, NP); end
    endtask

    task automatic test_backpressure();
        int ob, n, rcs;
        bit ok, stable;
        logic [DOW-1:0] held;
        ob = out_dat.size();
        pulse_start(32'd1);
        n = 0;
        while (!(host_out_valid === 1'b1 && out_dat.size() - ob == 2) && n < 2000) begin
            tick();
            n++;
        end
        host_out_ready = 1'b0;
        held = host_out_data;
        rcs = rc_rises;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (host_out_valid !== 1'b1 || host_out_data !== held) stable = 1'b0;
        end
        tests++; if (held !== DOW'(8'hA2)) begin fails++; $display("FAIL bp_held got %0h exp a2", held); end
        tests++; if (!stable) begin fails++; $display("FAIL bp_stable got 0 exp 1"); end
        tests++; if (rc_rises !== rcs) begin fails++; $display("FAIL bp_no_read got %0d exp %0d", rc_rises, rcs); end
        host_out_ready = 1'b1;
        wait_done(2000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_done_timeout got 0 exp 1"); end
        tests++; if (out_dat.size() - ob !== NP) begin fails++; $display("FAIL bp_nout got %0d exp %0d", out_dat.size() - ob, NP); end
        tests++; if (out_dat[ob+3] !== DOW'(8'hA3)) begin fails++; $display("FAIL bp_last got %0h exp a3", out_dat[ob+3]); end
        tick();
    endtask

    task automatic test_timeout();
        int ob, n;
        bit ok;
        ob = out_dat.size();
        core_en = 1'b0;
        pulse_start(32'd1);
        n = 0;
        while (md_read_ctrl !== 1'b1 && n < 2000) begin tick(); n++; end
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        tests++; if (n !== RTO) begin fails++; $display("FAIL to_latency got %0d exp %0d", n, RTO); end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL to_error got %b exp 1", error); end
        tests++; if (out_dat.size() !== ob) begin fails++; $display("FAIL to_nout got %0d exp %0d", out_dat.size() - ob, 0); end
        tick();
        tests++; if (busy !== 1'b0 || error !== 1'b1) begin fails++; $display("FAIL to_idle busy/err got %b/%b exp 0/1", busy, error); end
        core_en = 1'b1;
        pulse_start(32'd1);
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL to_clear got %b exp 0", error); end
        wait_done(2000, ok);
        tests++; if (!ok || error !== 1'b0) begin fails++; $display("FAIL to_rerun done/err got %b/%b exp 1/0", ok, error); end
        tests++; if (out_dat[ob] !== DOW'(8'hA0)) begin fails++; $display("FAIL to_rerun_out got %0h exp a0", out_dat[ob]); end
        tick();
    endtask

    task automatic test_reset_midrun();
        int n, ob;
        bit ok;
        pulse_start(32'd1);
        n = 0;
        while (md_elem_write !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        reset = 1'b1;
        tick();
        tests++; if (busy !== 1'b0 || host_in_ready !== 1'b0) begin fails++; $display("FAIL mr_idle busy/rdy got %b/%b exp 0/0", busy, host_in_ready); end
        tests++; if (md_elem_write !== 1'b0 || md_d_in !== '0) begin fails++; $display("FAIL mr_write got %b/%0h exp 0/0", md_elem_write, md_d_in); end
        tests++; if (done !== 1'b0 || error !== 1'b0 || md_step !== 32'd0) begin fails++; $display("FAIL mr_misc got %b/%b/%0d exp 0/0/0", done, error, md_step); end
        reset = 1'b0;
        tick();
        ob = out_dat.size();
        pulse_start(32'd1);
        repeat (3) tick();
        pulse_start(32'd5);
        num_steps = 32'd1;
        wait_done(2000, ok);
        tests++; if (!ok || md_step !== 32'd1) begin fails++; $display("FAIL busy_start done/step got %b/%0d exp 1/1", ok, md_step); end
        tests++; if (out_dat.size() - ob !== NP) begin fails++; $display("FAIL busy_start_nout got %0d exp %0d", out_dat.size() - ob, NP); end
        tick();
    endtask

    task automatic test_zero_steps();
        int wb, rcs, ob;
        bit ok;
        wb = wr_len.size(); rcs = rc_rises; ob = out_dat.size();
        pulse_start(32'd0);
        wait_done(2000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL z_done_timeout got 0 exp 1"); end
        tick();
        tests++; if (wr_len.size() - wb !== NP) begin fails++; $display("FAIL z_windows got %0d exp %0d", wr_len.size() - wb, NP); end
        tests++; if (wr_len[wb+NP-1] !== WH) begin fails++; $display("FAIL z_wlen got %0d exp %0d", wr_len[wb+NP-1], WH); end
        tests++; if (rc_rises !== rcs || out_dat.size() !== ob) begin fails++; $display("FAIL z_no_read got %0d/%0d exp 0/0", rc_rises - rcs, out_dat.size() - ob); end
        tests++; if (md_step !== 32'd0 || busy !== 1'b0) begin fails++; $display("FAIL z_end step/busy got %0d/%b exp 0/0", md_step, busy); end
    endtask

    task automatic test_multi_step();
        int ob;
        bit ok;
        ob = out_dat.size();
        pulse_start(32'd3);
        wait_done(5000, ok);
        tests++; if (!ok || md_step !== 32'd3) begin fails++; $display("FAIL ms_end done/step got %b/%0d exp 1/3", ok, md_step); end
        tick();
        tests++; if (out_dat.size() - ob !== 3 * NP) begin fails++; $display("FAIL ms_nout got %0d exp %0d", out_dat.size() - ob, 3 * NP); end
        for (int k = 0; k < 3 * NP; k++) begin
            tests++; if (out_dat[ob+k] !== DOW'(8'hA0 + k % NP)) begin fails++; $display("FAIL ms_out[%0d] got %0h exp %0h", k, out_dat[ob+k], 8'hA0 + k % NP); end
            tests++; if (out_step[ob+k] !== 32'(k / NP)) begin fails++; $display("FAIL ms_step[%0d] got %0d exp %0d", k, out_step[ob+k], k / NP); end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_steps = 32'd0;
        host_in_valid = 1'b1;
        host_out_ready = 1'b1;
        core_en = 1'b1;
        test_reset();
        test_load_unload();
        test_backpressure();
        test_timeout();
        test_reset_midrun();
        test_zero_steps();
        test_multi_step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
